// File: rtl/pc_lut_encoder.sv
// Reverse lookup for the branch-target LUT: finds the lowest valid entry whose
// stored PC equals the requested key, scanning one entry per clock.
//
// state  | meaning
// IDLE   | ready for a request; key latched on accept
// SEARCH | compare entry scan against key, one entry per edge
// RESP   | result held until the consumer takes it
module pc_lut_encoder #(
  parameter int D = 10,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [3:0]   wr_idx,
  input  logic [D-1:0] wr_target,
  input  logic         clr,
  input  logic         req_valid,
  input  logic [D-1:0] req_target,
  output logic         req_ready,
  output logic         rsp_valid,
  output logic         rsp_hit,
  output logic [3:0]   rsp_idx,
  input  logic         rsp_ready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]   state;
  logic [D-1:0] lut [N];
  logic [N-1:0] vld;
  logic [D-1:0] key;
  logic [3:0]   scan;
  logic         wr_ok;
  logic         cmp_hit;
  logic         scan_last;

  assign wr_ok     = ({1'b0, wr_idx} < 5'(N));
  assign cmp_hit   = vld[scan] && (lut[scan] == key);
  assign scan_last = (scan == 4'(N - 1));
  assign req_ready = (state == S_IDLE);

  // A write on the same edge as clr lands after the clear, so its entry stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < N; i++) lut[i] <= '0;
    end else begin
      if (clr) vld <= '0;
      if (wr_en && wr_ok) begin
        lut[wr_idx] <= wr_target;
        vld[wr_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      key       <= '0;
      scan      <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            key   <= req_target;
            scan  <= '0;
            state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (cmp_hit) begin
            rsp_hit   <= 1'b1;
            rsp_idx   <= scan;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (scan_last) begin
            rsp_hit   <= 1'b0;
            rsp_idx   <= '0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            scan <= scan + 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_lut_encoder.sv
// Directed and randomized checks of pc_lut_encoder against a plain array-search
// model of the table, including response latency and handshake behaviour.
module tb_pc_lut_encoder;
  localparam int D = 10;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n, wr_en, clr, req_valid, rsp_ready;
  logic [3:0]   wr_idx;
  logic [D-1:0] wr_target, req_target;
  logic         req_ready, rsp_valid, rsp_hit;
  logic [3:0]   rsp_idx;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int acc_edge = 0;

  logic [D-1:0] m_lut [N];
  bit           m_vld [N];

  pc_lut_encoder #(.D(D), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_target(wr_target),
    .clr(clr), .req_valid(req_valid), .req_target(req_target), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_lut[i] = '0;
      m_vld[i] = 1'b0;
    end
  endtask

  task automatic write(input int idx, input int val, input bit with_clr);
    wr_en = 1'b1; wr_idx = 4'(idx); wr_target = D'(val); clr = with_clr;
    tick();
    wr_en = 1'b0; clr = 1'b0;
    if (with_clr) for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
    m_lut[idx] = D'(val);
    m_vld[idx] = 1'b1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
  endtask

  task automatic start_lookup(input int key);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_target = D'(key);
    tick();
    acc_edge = edge_cnt;
    req_valid = 1'b0;
  endtask

  // Expected result: lowest valid entry holding the key; latency idx+1, or N on a miss.
  task automatic wait_rsp(input string tag, input int key, input int hold);
    int exp_idx, exp_lat;
    bit exp_hit;
    exp_hit = 1'b0; exp_idx = 0;
    for (int i = N - 1; i >= 0; i--)
      if (m_vld[i] && m_lut[i] == D'(key)) begin exp_hit = 1'b1; exp_idx = i; end
    exp_lat = exp_hit ? exp_idx + 1 : N;
    while (!rsp_valid && (edge_cnt - acc_edge) < 40) tick();
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_latency"}, 32'(edge_cnt - acc_edge), 32'(exp_lat));
    chk({tag, "_hit"}, 32'(rsp_hit), 32'(exp_hit));
    chk({tag, "_idx"}, 32'(rsp_idx), 32'(exp_idx));
    for (int c = 0; c < hold; c++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_hit"}, 32'(rsp_hit), 32'(exp_hit));
      chk({tag, "_hold_idx"}, 32'(rsp_idx), 32'(exp_idx));
      chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_drain_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic lookup(input string tag, input int key, input int hold);
    start_lookup(key);
    wait_rsp(tag, key, hold);
  endtask

  initial begin
    int vals [6];
    int key;
    vals = '{0, 11, 41, 99, 72, 87};
    rst_n = 1'b0; wr_en = 1'b0; clr = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    wr_idx = '0; wr_target = '0; req_target = '0;
    model_clear();
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    chk("rst_rsp_idx", 32'(rsp_idx), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) write(i, vals[i], 1'b0);
    lookup("hit99", 99, 0);
    lookup("hit0", 0, 0);
    lookup("miss50", 50, 0);

    write(7, 41, 1'b0);
    lookup("dup41", 41, 0);
    do_clr();
    lookup("clr_miss99", 99, 0);
    write(9, 41, 1'b0);
    lookup("after_clr41", 41, 0);

    write(3, 99, 1'b1);
    lookup("clr_wr_same_edge", 99, 0);
    lookup("clr_wr_other_gone", 41, 0);

    start_lookup(200);
    repeat (4) tick();
    write(10, 200, 1'b0);
    wait_rsp("midsearch200", 200, 0);

    lookup("backpressure", 99, 5);

    start_lookup(99);
    req_valid = 1'b1; req_target = D'(200);
    repeat (2) tick();
    req_valid = 1'b0;
    wait_rsp("ignored_req", 99, 0);

    write(4, 11, 1'b0);
    start_lookup(11);
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_hit", 32'(rsp_hit), 32'd0);
    chk("abort_rsp_idx", 32'(rsp_idx), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    lookup("post_reset11", 11, 0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) do_clr();
      repeat ($urandom_range(0, 3)) write($urandom_range(0, N - 1), $urandom_range(0, 7), $urandom_range(0, 5) == 0);
      key = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 7));
      lookup("random", key, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
